// File: rtl/classifier_lookup_nway.sv
// ============================================================================
// classifier_lookup_nway : N-way cuckoo-hash lookup with key compare and aging
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module classifier_lookup_nway #(
  parameter int NWAYS             = 2,
  parameter int DEPTH_NBITS       = 12,
  parameter int VALUE_DEPTH_NBITS = 12,
  parameter int KEY_NBITS         = 104,
  parameter int ETIME_NBITS       = 16,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [ETIME_NBITS-1:0]                 current_time,
  input  logic [ETIME_NBITS-1:0]                 aging_time,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [KEY_NBITS-1:0]                   req_key,
  input  logic [NWAYS*DEPTH_NBITS-1:0]           req_hash,
  output logic [NWAYS-1:0]                       bkt_rd,
  output logic [NWAYS*DEPTH_NBITS-1:0]           bkt_raddr,
  input  logic [NWAYS-1:0]                       bkt_ack,
  input  logic [NWAYS*(VALUE_DEPTH_NBITS+1)-1:0] bkt_rdata,
  output logic                                   key_rd,
  output logic [VALUE_DEPTH_NBITS-1:0]           key_raddr,
  input  logic                                   key_ack,
  input  logic [KEY_NBITS-1:0]                   key_rdata,
  output logic                                   etime_rd,
  output logic [VALUE_DEPTH_NBITS-1:0]           etime_raddr,
  input  logic                                   etime_ack,
  input  logic [ETIME_NBITS-1:0]                 etime_rdata,
  output logic                                   resp_valid,
  output logic                                   resp_hit,
  output logic                                   resp_expired,
  output logic                                   resp_timeout,
  output logic [1:0]                             resp_way,
  output logic [VALUE_DEPTH_NBITS-1:0]           resp_idx,
  output logic                                   sup_valid,
  output logic [NWAYS*DEPTH_NBITS-1:0]           sup_hash,
  output logic [KEY_NBITS-1:0]                   sup_key
);

  localparam int IDX_W  = VALUE_DEPTH_NBITS;
  localparam int HASH_W = NWAYS * DEPTH_NBITS;
  localparam int BKT_W  = VALUE_DEPTH_NBITS + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    BKT_RD     = 4'd1,
    BKT_WAIT   = 4'd2,
    SCAN       = 4'd3,
    KEY_RD     = 4'd4,
    KEY_WAIT   = 4'd5,
    ETIME_RD   = 4'd6,
    ETIME_WAIT = 4'd7,
    HIT        = 4'd8,
    EXPIRED    = 4'd9,
    MISS       = 4'd10,
    TERR       = 4'd11
  } state_t;

  state_t state, state_nxt;

  logic [KEY_NBITS-1:0]   key_q;
  logic [HASH_W-1:0]      hash_q;
  logic [NWAYS-1:0]       acked;
  logic [NWAYS-1:0]       bkt_vld;
  logic [IDX_W-1:0]       bkt_idx [NWAYS];
  logic [2:0]             scan_ptr;
  logic [1:0]             cur_way;
  logic [IDX_W-1:0]       cur_idx;
  logic [TO_W-1:0]        wait_cnt;

  logic [NWAYS-1:0]       rd_vld;
  logic [IDX_W-1:0]       rd_idx [NWAYS];
  logic                   found;
  logic [1:0]             found_way;
  logic [IDX_W-1:0]       found_idx;
  logic [ETIME_NBITS-1:0] age;
  logic                   key_match;
  logic                   expiring;
  logic                   in_wait;
  logic                   term_nxt;
  logic                   accept;

  generate
    for (genvar g = 0; g < NWAYS; g++) begin : g_unpack
      assign rd_vld[g] = bkt_rdata[g*BKT_W + IDX_W];
      assign rd_idx[g] = bkt_rdata[g*BKT_W +: IDX_W];
    end
  endgenerate

  assign age       = current_time - etime_rdata;
  assign key_match = (key_rdata == key_q);
  assign expiring  = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign in_wait   = (state == BKT_WAIT) || (state == KEY_WAIT) || (state == ETIME_WAIT);
  assign accept    = (state == IDLE) && req_valid;
  assign term_nxt  = (state_nxt == HIT) || (state_nxt == EXPIRED) ||
                     (state_nxt == MISS) || (state_nxt == TERR);

  // Descending walk so the lowest eligible way is the one left selected.
  always_comb begin
    found     = 1'b0;
    found_way = '0;
    found_idx = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (bkt_vld[w] && (3'(w) >= scan_ptr)) begin
        found     = 1'b1;
        found_way = 2'(w);
        found_idx = bkt_idx[w];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req_valid) state_nxt = BKT_RD;
      BKT_RD:     state_nxt = BKT_WAIT;
      BKT_WAIT: begin
        if (&(acked | bkt_ack)) state_nxt = SCAN;
        else if (expiring)      state_nxt = TERR;
      end
      SCAN:       state_nxt = found ? KEY_RD : MISS;
      KEY_RD:     state_nxt = KEY_WAIT;
      KEY_WAIT: begin
        if (key_ack)       state_nxt = key_match ? ETIME_RD : SCAN;
        else if (expiring) state_nxt = TERR;
      end
      ETIME_RD:   state_nxt = ETIME_WAIT;
      ETIME_WAIT: begin
        if (etime_ack)     state_nxt = (age <= aging_time) ? HIT : EXPIRED;
        else if (expiring) state_nxt = TERR;
      end
      HIT, EXPIRED, MISS, TERR: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= in_wait ? wait_cnt + TO_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q    <= '0;
      hash_q   <= '0;
      acked    <= '0;
      bkt_vld  <= '0;
      scan_ptr <= '0;
      cur_way  <= '0;
      cur_idx  <= '0;
      for (int w = 0; w < NWAYS; w++) bkt_idx[w] <= '0;
    end else begin
      if (accept) begin
        key_q    <= req_key;
        hash_q   <= req_hash;
        acked    <= '0;
        bkt_vld  <= '0;
        scan_ptr <= '0;
      end
      // Only the first ack per way is honoured; repeats are dropped.
      if (state == BKT_WAIT) begin
        acked <= acked | bkt_ack;
        for (int w = 0; w < NWAYS; w++) begin
          if (bkt_ack[w] && !acked[w]) begin
            bkt_vld[w] <= rd_vld[w];
            bkt_idx[w] <= rd_idx[w];
          end
        end
      end
      if ((state == SCAN) && found) begin
        cur_way <= found_way;
        cur_idx <= found_idx;
      end
      if ((state == KEY_WAIT) && key_ack && !key_match)
        scan_ptr <= {1'b0, cur_way} + 3'd1;
    end
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_ready    <= 1'b1;
      bkt_rd       <= '0;
      bkt_raddr    <= '0;
      key_rd       <= 1'b0;
      key_raddr    <= '0;
      etime_rd     <= 1'b0;
      etime_raddr  <= '0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_expired <= 1'b0;
      resp_timeout <= 1'b0;
      resp_way     <= '0;
      resp_idx     <= '0;
      sup_valid    <= 1'b0;
      sup_hash     <= '0;
      sup_key      <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      bkt_rd     <= {NWAYS{state_nxt == BKT_RD}};
      key_rd     <= (state_nxt == KEY_RD);
      etime_rd   <= (state_nxt == ETIME_RD);
      resp_valid <= term_nxt;
      sup_valid  <= (state_nxt == MISS) || (state_nxt == EXPIRED);

      if (accept)                                    bkt_raddr   <= req_hash;
      if ((state == SCAN) && found)                  key_raddr   <= found_idx;
      if ((state == KEY_WAIT) && key_ack && key_match) etime_raddr <= cur_idx;

      if (term_nxt) begin
        resp_hit     <= (state_nxt == HIT);
        resp_expired <= (state_nxt == EXPIRED);
        resp_timeout <= (state_nxt == TERR);
        if ((state_nxt == HIT) || (state_nxt == EXPIRED)) begin
          resp_way <= cur_way;
          resp_idx <= cur_idx;
        end else begin
          resp_way <= '0;
          resp_idx <= '0;
        end
      end
      if ((state_nxt == MISS) || (state_nxt == EXPIRED)) begin
        sup_hash <= hash_q;
        sup_key  <= key_q;
      end
    end
  end

endmodule

`default_nettype wire
